// File: rtl/result_readout.sv
// Post-run result extractor: freezes CPU counters on program end and
// streams the M result words out of byte-wide data memory.
module result_readout #(
  parameter int M  = 3,
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int AW = 16
) (
  input  logic                 CLOCK_50,
  input  logic                 reset,
  input  logic                 done,
  input  logic [15:0]          clock_count,
  input  logic [15:0]          instr_cnt,
  output logic                 mem_rd,
  output logic [AW-1:0]        mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [W-1:0]         res_data,
  output logic [$clog2(M)-1:0] res_index,
  output logic                 stats_valid,
  output logic [15:0]          stats_clk,
  output logic [15:0]          stats_instr,
  output logic                 busy,
  output logic                 finished
);

  localparam int IW = $clog2(M);
  localparam logic [AW-1:0] BASE = AW'(4*M*N + 4*N);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_HOLD,
    S_FIN
  } state_t;

  state_t        r_state;
  state_t        w_state_nx;
  logic          r_done_q;
  logic [IW-1:0] r_idx;
  logic [2:0]    r_step;
  logic [W-9:0]  r_shift;
  logic          w_start;
  logic          w_last;

  assign w_start = done & ~r_done_q;
  assign w_last  = (r_idx == IW'(M-1));

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nx;
  end

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      S_IDLE: if (w_start) w_state_nx = S_READ;
      S_READ: if (r_step == 3'd4) w_state_nx = S_HOLD;
      S_HOLD: if (res_ready) w_state_nx = w_last ? S_FIN : S_READ;
      S_FIN:  if (!done) w_state_nx = S_IDLE;
    endcase
  end

  // Steps 0..3 issue byte addresses; the memory answers one edge late,
  // so bytes land on steps 1..4 and the word completes on step 4.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_done_q    <= 1'b0;
      r_idx       <= '0;
      r_step      <= '0;
      r_shift     <= '0;
      mem_addr    <= '0;
      res_data    <= '0;
      res_index   <= '0;
      stats_valid <= 1'b0;
      stats_clk   <= '0;
      stats_instr <= '0;
    end else begin
      r_done_q <= done;
      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            stats_clk   <= clock_count;
            stats_instr <= instr_cnt;
            stats_valid <= 1'b1;
            r_idx       <= '0;
            r_step      <= '0;
            mem_addr    <= BASE;
          end
        end
        S_READ: begin
          r_step  <= r_step + 3'd1;
          r_shift <= {r_shift[W-17:0], mem_rdata};
          if (r_step < 3'd3)
            mem_addr <= mem_addr + AW'(1);
          if (r_step == 3'd4) begin
            res_data  <= {r_shift, mem_rdata};
            res_index <= r_idx;
          end
        end
        S_HOLD: begin
          // Address sits on byte 3 of this word, so +1 is the next base.
          if (res_ready && !w_last) begin
            r_idx    <= r_idx + IW'(1);
            r_step   <= '0;
            mem_addr <= mem_addr + AW'(1);
          end
        end
        S_FIN: begin
        end
      endcase
    end
  end

  assign mem_rd    = (r_state == S_READ) && (r_step < 3'd4);
  assign res_valid = (r_state == S_HOLD);
  assign busy      = (r_state == S_READ) || (r_state == S_HOLD);
  assign finished  = (r_state == S_FIN);

endmodule

// File: tb/tb_result_readout.sv
// Directed bench for result_readout: byte memory model, handshake
// logger and hand-computed expected words, latencies and addresses.
module tb_result_readout;

  localparam int M  = 3;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          done;
  logic [15:0]   cc;
  logic [15:0]   ic;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_rdata;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_data;
  logic [1:0]    res_index;
  logic          stats_valid;
  logic [15:0]   stats_clk;
  logic [15:0]   stats_instr;
  logic          busy;
  logic          finished;

  result_readout #(.M(M), .N(N), .W(W), .AW(AW)) dut (
    .CLOCK_50    (clk),
    .reset       (rst),
    .done        (done),
    .clock_count (cc),
    .instr_cnt   (ic),
    .mem_rd      (mem_rd),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .res_valid   (res_valid),
    .res_ready   (res_ready),
    .res_data    (res_data),
    .res_index   (res_index),
    .stats_valid (stats_valid),
    .stats_clk   (stats_clk),
    .stats_instr (stats_instr),
    .busy        (busy),
    .finished    (finished)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) mem_rdata <= mem[mem_addr[7:0]];

  logic [31:0] exp_w [3];
  logic [31:0] acc_data [$];
  int          acc_idx  [$];
  int          acc_cyc  [$];
  logic [15:0] addr_q   [$];
  int          cyc      = 0;
  int          rd_cnt   = 0;
  int          overlap  = 0;
  int          checks   = 0;
  int          errors   = 0;
  int          k;
  int          c0;
  int          fin_cyc;
  int          rd0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    if (res_valid && res_ready) begin
      acc_data.push_back(res_data);
      acc_idx.push_back(int'(res_index));
      acc_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (mem_rd) begin
      rd_cnt++;
      addr_q.push_back(mem_addr);
    end
    if (mem_rd && res_valid) overlap++;
  endtask

  task automatic clear_log();
    acc_data.delete();
    acc_idx.delete();
    acc_cyc.delete();
    addr_q.delete();
    rd_cnt = 0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!res_valid && n < 12) begin
      tick();
      n++;
    end
  endtask

  task automatic wait_fin();
    int n;
    n = 0;
    while (!finished && n < 80) begin
      tick();
      n++;
    end
    check("fin_seen", finished, 1);
  endtask

  task automatic check_words(input string tag);
    check({tag, "_nwords"}, acc_data.size(), 3);
    for (int i = 0; i < acc_data.size() && i < 3; i++) begin
      check($sformatf("%s_w%0d", tag, i), acc_data[i], exp_w[i]);
      check($sformatf("%s_i%0d", tag, i), acc_idx[i], i);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_rd"},    mem_rd, 0);
    check({tag, "_addr"},  mem_addr, 0);
    check({tag, "_valid"}, res_valid, 0);
    check({tag, "_data"},  res_data, 0);
    check({tag, "_idx"},   res_index, 0);
    check({tag, "_sv"},    stats_valid, 0);
    check({tag, "_sclk"},  stats_clk, 0);
    check({tag, "_sins"},  stats_instr, 0);
    check({tag, "_busy"},  busy, 0);
    check({tag, "_fin"},   finished, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    exp_w[0] = 32'h0000001E;
    exp_w[1] = 32'hFFFFFFF6;
    exp_w[2] = 32'h00000100;
    for (int i = 0; i < 256; i++) mem[i] = 8'hA5;
    for (int i = 0; i < 3; i++)
      for (int b = 0; b < 4; b++)
        mem[64 + 4*i + b] = exp_w[i][31-8*b -: 8];

    rst = 1'b1;
    done = 1'b0;
    res_ready = 1'b0;
    cc = '0;
    ic = '0;
    repeat (2) tick();
    check_zero("reset");
    rst = 1'b0;
    tick();
    clear_log();

    // Run 1: free-flowing sink, counters move after start, extra done pulse.
    cc = 16'h0123;
    ic = 16'h0061;
    res_ready = 1'b1;
    done = 1'b1;
    tick();
    c0 = cyc;
    check("e0_rd",   mem_rd, 1);
    check("e0_addr", mem_addr, 64);
    check("e0_busy", busy, 1);
    check("e0_sv",   stats_valid, 1);
    check("e0_sclk", stats_clk, 16'h0123);
    check("e0_sins", stats_instr, 16'h0061);
    check("e0_vld",  res_valid, 0);
    k = 0;
    while (!res_valid && k < 12) begin
      cc = cc + 16'd7;
      ic = ic + 16'd3;
      tick();
      k++;
      if (k == 2) done = 1'b0;
      if (k == 3) done = 1'b1;
    end
    check("r1_lat",  k, 5);
    check("r1_d0",   res_data, 32'h0000001E);
    check("r1_i0",   res_index, 0);
    wait_fin();
    fin_cyc = cyc;
    check_words("r1");
    if (acc_cyc.size() == 3) begin
      check("r1_c0",  acc_cyc[0], c0 + 5);
      check("r1_gap1", acc_cyc[1] - acc_cyc[0], 6);
      check("r1_gap2", acc_cyc[2] - acc_cyc[1], 6);
      check("r1_fin",  fin_cyc, acc_cyc[2] + 1);
    end
    check("r1_sclk", stats_clk, 16'h0123);
    check("r1_sins", stats_instr, 16'h0061);
    check("r1_busy", busy, 0);
    check("r1_hold", res_data, 32'h00000100);
    check("r1_rdcnt", rd_cnt, 12);
    for (int i = 0; i < addr_q.size() && i < 12; i++)
      check($sformatf("addr%0d", i), addr_q[i], 64 + i);
    tick();
    check("r1_finhold", finished, 1);
    done = 1'b0;
    tick();
    check("r1_idle_fin",  finished, 0);
    check("r1_idle_busy", busy, 0);
    check("r1_idle_rd",   mem_rd, 0);
    clear_log();

    // Run 2: fresh start re-latches stats; backpressure on word 1.
    cc = 16'h0456;
    ic = 16'h0077;
    done = 1'b1;
    tick();
    check("r2_sclk", stats_clk, 16'h0456);
    check("r2_sins", stats_instr, 16'h0077);
    k = 0;
    while (acc_data.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    res_ready = 1'b0;
    wait_valid(k);
    check("bp_w1",  res_data, 32'hFFFFFFF6);
    check("bp_i1",  res_index, 1);
    rd0 = rd_cnt;
    repeat (10) tick();
    check("bp_vld",  res_valid, 1);
    check("bp_hold", res_data, 32'hFFFFFFF6);
    check("bp_idx",  res_index, 1);
    check("bp_nord", rd_cnt, rd0);
    res_ready = 1'b1;
    tick();
    check("bp_acc_vld",  res_valid, 0);
    check("bp_acc_rd",   mem_rd, 1);
    check("bp_acc_addr", mem_addr, 72);
    wait_valid(k);
    check("bp_lat", k, 5);
    check("bp_w2",  res_data, 32'h00000100);
    check("bp_i2",  res_index, 2);
    wait_fin();
    check_words("r2");
    check("r2_rdcnt", rd_cnt, 12);
    done = 1'b0;
    tick();
    clear_log();

    // Run 3: reset in the middle of word 1, then restart.
    done = 1'b1;
    tick();
    k = 0;
    while (acc_data.size() < 1 && k < 20) begin
      tick();
      k++;
    end
    tick();
    tick();
    check("r3_midread", mem_rd, 1);
    rst = 1'b1;
    #2;
    check_zero("async");
    done = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    clear_log();
    done = 1'b1;
    tick();
    check("r3_addr", mem_addr, 64);
    wait_valid(k);
    check("r3_lat", k, 5);
    check("r3_i0",  res_index, 0);
    wait_fin();
    check_words("r3");
    check("r3_rdcnt", rd_cnt, 12);
    check("overlap",  overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_readout.md
Name: result_readout

Overview:
- Downstream consumer of the RISC-V CPU core. It watches the CPU's program-end flag and freezes the cycle and instruction counters.
- It then reads the M result words of the matrix-vector product out of byte-wide data memory and streams them out over a valid/ready interface.
- Purpose: in-hardware result extraction for FPGA runs, replacing simulation-only hierarchical peeks into D_Memory.

Parameters:
- M, 3, matrix rows = number of result words.
- N, 4, matrix columns; sets the result base address.
- W, 32, result word width (4 bytes).
- AW, 16, data-memory byte-address width.

Ports:
- CLOCK_50  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- done  in  1  CPU program-end flag.
- clock_count  in  16  CPU cycle counter.
- instr_cnt  in  16  CPU retired-instruction counter.
- mem_rd  out  1  data-memory read strobe.
- mem_addr  out  AW  data-memory byte address.
- mem_rdata  in  8  read byte; valid on the edge after the edge that registered mem_addr/mem_rd.
- res_valid  out  1  result word available.
- res_ready  in  1  sink accepts the word.
- res_data  out  W  result word.
- res_index  out  $clog2(M)  row index of res_data.
- stats_valid  out  1  frozen counters valid.
- stats_clk  out  16  frozen clock_count.
- stats_instr  out  16  frozen instr_cnt.
- busy  out  1  readout in progress.
- finished  out  1  all M words transferred.

Behaviour:
- Reset (async, immediate): state=IDLE; mem_rd, res_valid, stats_valid, busy, finished = 0; mem_addr, res_data, res_index, stats_clk, stats_instr = 0; done_q = 0. Reset mid-readout aborts it; no partial word is ever presented.
- Start detection: done_q registers done. The start event is the edge E0 at which done=1 and done_q=0, in state IDLE.
  - Rising done in any other state is ignored.
  - done already high when reset releases: the first edge after release counts as a rising edge.
- At E0:
  - stats_clk/stats_instr latch the values sampled at E0; stats_valid=1.
  - idx=0; state=READ; busy=1.
  - mem_addr=BASE, mem_rd=1, where BASE = 4*M*N + 4*N (64 at defaults).
  - Stats hold until reset or the next start.
- READ:
  - mem_addr steps BASE+4*idx+0..+3 on four consecutive edges; mem_rd=1 for exactly those 4 cycles.
  - Bytes are captured one edge after each address and shifted in MSB-first (big-endian): res_data = {mem[a], mem[a+1], mem[a+2], mem[a+3]}.
  - At E5 (the edge capturing byte 3): res_valid=1, res_index=idx, mem_rd=0; state=HOLD.
- HOLD:
  - res_data and res_index stay stable while res_valid && !res_ready.
  - On an edge with res_ready=1: res_valid=0.
    - If idx<M-1: idx++, mem_addr=next word base, mem_rd=1, state=READ. The next word is valid 5 edges later.
    - Otherwise: state=FIN.
  - res_ready held high gives a steady rate of one word per 6 cycles.
- FIN: finished=1, busy=0; the last res_data is held. When done returns to 0: state=IDLE, finished=0.
- IDLE: all strobes low; res_ready is ignored.
- Arithmetic:
  - Address arithmetic is AW-bit, unsigned, wrap-around.
  - res_data is raw bits with no sign processing; the sink interprets it as signed two's complement.
  - Counters are copied verbatim, with no CPI computation in hardware.
- mem_rd never asserts outside READ. res_valid and mem_rd are never both high.

Test Plan:
- Default params, memory bytes 64..75 = 00 00 00 1E, FF FF FF F6, 00 00 01 00; done rises with res_ready=1:
  - res_valid first rises at E0+5, with res_data=0x0000001E, index 0.
  - Then 0xFFFFFFF6 (-10) at index 1 and 0x00000100 at index 2, one per 6 cycles.
  - finished rises one edge after the third transfer.
- clock_count=0x0123 and instr_cnt=0x0061 at E0, both changing afterwards:
  - stats_clk=0x0123 and stats_instr=0x0061, stable through FIN.
- Backpressure: hold res_ready=0 for 10 cycles on word 1.
  - res_data stays unchanged, with no mem_rd activity, until ready.
  - Word 2 is valid exactly 5 edges after the accepting edge.
- Assert reset during the READ of word 1:
  - All outputs are 0 immediately, with no clock required.
  - A new done rising edge restarts from index 0 and yields correct words.
- Second done pulse while busy: ignored, and the readout completes normally. After done falls in FIN, a new rising edge starts a fresh run and re-latches the stats.
- Address check: mem_addr sequence is 64..67, 68..71, 72..75, and mem_rd is high for exactly 12 cycles in total.
